// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI word size, idle fill byte and transmit FSM states.
// Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int         SPI_WORD_W    = 8;
    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    typedef enum logic {
        SPI_TX_IDLE  = 1'b0,
        SPI_TX_SHIFT = 1'b1
    } spi_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer with rise/fall strobes for an async pin.
// Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~prev_q;
    assign fall_o  = ~level_o &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_tx_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_peripheral
// Purpose  : SPI mode-0 peripheral transmitter, MSB first, one-byte buffer.
// Revision : 1.0  initial release
// ============================================================================
module spi_tx_peripheral
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_WORD_W,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = SPI_IDLE_BYTE,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  spi_cs_n,
    output logic                  CIPO,
    output logic                  cipo_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  byte_sent,
    output logic                  underrun,
    output logic                  frame_abort
);

    localparam int                 c_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_WORD  = c_CNT_W'(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_i(SCLK),
        .level_o(), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .async_i(spi_cs_n),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_tx_state_t         state_q, state_d;
    logic [c_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  cipo_q, cipo_d;
    logic                  oe_q, oe_d;
    logic                  sent_q, sent_d;
    logic                  under_q, under_d;
    logic                  abort_q, abort_d;
    logic                  load;
    logic                  accept;
    logic [c_CNT_W-1:0]    cnt_inc;

    assign accept  = tx_valid & ~hold_full_q;
    assign cnt_inc = bit_cnt_q + c_ONE;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cipo_d      = cipo_q;
        oe_d        = oe_q;
        sent_d      = 1'b0;
        under_d     = 1'b0;
        abort_d     = 1'b0;
        load        = 1'b0;

        case (state_q)
            SPI_TX_IDLE: begin
                oe_d = 1'b0;
                if (cs_fall) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
                    state_d   = SPI_TX_SHIFT;
                end
            end
            SPI_TX_SHIFT: begin
                if (cs_rise) begin
                    oe_d      = 1'b0;
                    state_d   = SPI_TX_IDLE;
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                end else if (!cs_level && sclk_rise) begin
                    if (cnt_inc == c_WORD) begin
                        bit_cnt_d = '0;
                        sent_d    = 1'b1;
                    end else begin
                        bit_cnt_d = cnt_inc;
                    end
                end else if (!cs_level && sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        shift_d = shift_q << 1;
                        cipo_d  = shift_q[DATA_WIDTH-2];
                    end
                end
            end
            default: state_d = SPI_TX_IDLE;
        endcase

        // A pending byte wins the load; otherwise fill and flag the underrun.
        if (load) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                cipo_d      = hold_q[DATA_WIDTH-1];
                hold_full_d = 1'b0;
            end else begin
                shift_d = IDLE_BYTE;
                cipo_d  = IDLE_BYTE[DATA_WIDTH-1];
                under_d = 1'b1;
            end
        end

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SPI_TX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            sent_q      <= 1'b0;
            under_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cipo_q      <= cipo_d;
            oe_q        <= oe_d;
            sent_q      <= sent_d;
            under_q     <= under_d;
            abort_q     <= abort_d;
        end
    end

    assign CIPO        = cipo_q;
    assign cipo_oe     = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign byte_sent   = sent_q;
    assign underrun    = under_q;
    assign frame_abort = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_peripheral
// Purpose  : Directed self-checking bench acting as the external SPI controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_tx_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCLK;
    logic       spi_cs_n;
    logic       CIPO;
    logic       cipo_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       byte_sent;
    logic       underrun;
    logic       frame_abort;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_under = 0;
    int n_abort = 0;

    spi_tx_peripheral dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .spi_cs_n(spi_cs_n),
        .CIPO(CIPO), .cipo_oe(cipo_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .byte_sent(byte_sent), .underrun(underrun), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_sent)   n_sent++;
        if (underrun)    n_under++;
        if (frame_abort) n_abort++;
    end

    typedef struct {
        logic       do_push;
        logic [7:0] push_val;
        logic [7:0] exp_rx;
        int         exp_under;
    } frame_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=busy required=ready");
        end else begin
            @(posedge clk);
        end
        #1 tx_valid = 1'b0;
    endtask

    // SCLK period is 8 clk; the final rise leaves SCLK high so end_frame
    // raises CS before the last fall.
    task automatic xfer(input int nbits, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b1;
            rx   = {rx[14:0], CIPO};
            #40;
            if (i < nbits - 1) SCLK = 1'b0;
            #40;
        end
    endtask

    task automatic start_frame();
        spi_cs_n = 1'b0;
        #80;
    endtask

    task automatic end_frame();
        spi_cs_n = 1'b1;
        #40 SCLK = 1'b0;
        #80;
    endtask

    frame_vec_t vecs[5];
    logic [15:0] rx;
    int s0, u0, a0;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'hA5, 0};
        vecs[1] = '{1'b0, 8'h00, 8'hFF, 1};
        vecs[2] = '{1'b1, 8'h00, 8'h00, 0};
        vecs[3] = '{1'b1, 8'h7E, 8'h7E, 0};
        vecs[4] = '{1'b1, 8'h01, 8'h01, 0};

        rst = 1'b1; SCLK = 1'b0; spi_cs_n = 1'b1; tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cipo", CIPO, 0);
        chk("reset_oe", cipo_oe, 0);
        chk("reset_ready", tx_ready, 1);
        chk("reset_pulses", {byte_sent, underrun, frame_abort}, 0);
        rst = 1'b0;
        #50;

        for (int v = 0; v < 5; v++) begin
            s0 = n_sent; u0 = n_under; a0 = n_abort;
            if (vecs[v].do_push) begin
                push(vecs[v].push_val);
                #1 chk($sformatf("v%0d_ready_full", v), tx_ready, 0);
            end
            start_frame();
            chk($sformatf("v%0d_oe_active", v), cipo_oe, 1);
            chk($sformatf("v%0d_under_at_csfall", v), n_under - u0, vecs[v].exp_under);
            xfer(8, rx);
            end_frame();
            chk($sformatf("v%0d_rx", v), rx[7:0], vecs[v].exp_rx);
            chk($sformatf("v%0d_sent", v), n_sent - s0, 1);
            chk($sformatf("v%0d_under_total", v), n_under - u0, vecs[v].exp_under);
            chk($sformatf("v%0d_abort", v), n_abort - a0, 0);
            chk($sformatf("v%0d_ready_after", v), tx_ready, 1);
            chk($sformatf("v%0d_oe_after", v), cipo_oe, 0);
        end

        // Back-to-back words with the second byte pushed mid-word.
        s0 = n_sent; u0 = n_under;
        push(8'h3C);
        start_frame();
        fork
            xfer(16, rx);
            begin #(80 * 3); push(8'hC3); end
        join
        end_frame();
        chk("b2b_rx", rx, 16'h3CC3);
        chk("b2b_sent", n_sent - s0, 2);
        chk("b2b_under", n_under - u0, 0);

        // Partial word then CS rise, followed by an underrun frame.
        s0 = n_sent; u0 = n_under; a0 = n_abort;
        push(8'h81);
        start_frame();
        xfer(4, rx);
        end_frame();
        chk("abort_rx4", rx[3:0], 4'h8);
        chk("abort_pulse", n_abort - a0, 1);
        chk("abort_oe", cipo_oe, 0);
        chk("abort_sent", n_sent - s0, 0);
        u0 = n_under;
        start_frame();
        chk("abort_next_under", n_under - u0, 1);
        fork
            xfer(16, rx);
            begin #(80 * 3); push(8'h99); end
        join
        end_frame();
        chk("abort_next_rx", rx, 16'hFF99);
        chk("abort_next_abort", n_abort - a0, 1);

        // Reset in the middle of a word.
        a0 = n_abort;
        push(8'h5A);
        start_frame();
        xfer(5, rx);
        chk("rst_mid_rx5", rx[4:0], 5'b01011);
        @(negedge clk);
        rst = 1'b1; spi_cs_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_oe", cipo_oe, 0);
        chk("rst_mid_cipo", CIPO, 0);
        chk("rst_mid_ready", tx_ready, 1);
        chk("rst_mid_pulses", {byte_sent, underrun, frame_abort}, 0);
        rst = 1'b0; SCLK = 1'b0;
        #80;
        start_frame();
        xfer(8, rx);
        end_frame();
        chk("rst_next_rx", rx[7:0], 8'hFF);
        chk("rst_no_abort", n_abort - a0, 0);

        // SCLK toggling with CS deasserted must be ignored.
        s0 = n_sent; u0 = n_under; a0 = n_abort;
        push(8'h12);
        for (int i = 0; i < 8; i++) begin
            #40 SCLK = 1'b1;
            #40 SCLK = 1'b0;
        end
        #80;
        chk("cshigh_pulses", (n_sent - s0) + (n_under - u0) + (n_abort - a0), 0);
        chk("cshigh_oe", cipo_oe, 0);
        chk("cshigh_ready", tx_ready, 0);
        start_frame();
        xfer(8, rx);
        end_frame();
        chk("cshigh_next_rx", rx[7:0], 8'h12);
        chk("cshigh_next_under", n_under - u0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/spi_tx_peripheral.md
Name: spi_tx_peripheral

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) peripheral transmit path, MSB first; drives CIPO back to the external controller on the same SCLK/spi_cs_n pins used for image upload.
- Returns result and status bytes, e.g. the 4-bit classification zero-extended to a byte, to the external controller.
- Oversamples SCLK and spi_cs_n in the clk domain; buffers one pending byte behind the active shift register; sends IDLE_BYTE on underrun.
- Sits beside spi_peripheral under system_controller; the FSM controller feeds it through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- IDLE_BYTE, 8'hFF, word shifted out when no byte is pending at a load point.
- SYNC_STAGES, 2, synchronizer depth for SCLK and spi_cs_n (minimum 2).

Ports:
- clk  in  1  system clock; SCLK frequency is at most clk/8.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- CIPO  out  1  serial data to the controller.
- cipo_oe  out  1  output enable for the CIPO pad; high while the frame is active.
- tx_data  in  DATA_WIDTH  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty; a byte is accepted when tx_valid && tx_ready.
- byte_sent  out  1  one-cycle pulse when a full word has been clocked out.
- underrun  out  1  one-cycle pulse when IDLE_BYTE is loaded because the holding register was empty.
- frame_abort  out  1  one-cycle pulse when spi_cs_n rises with bit_cnt != 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - CIPO=0, cipo_oe=0, tx_ready=1, byte_sent=0, underrun=0, frame_abort=0.
  - Holding register cleared, shift register cleared, bit_cnt=0, state=IDLE.
  - Synchronizer flops load idle values: SCLK=0, spi_cs_n=1.
  - Reset mid-frame aborts silently (no frame_abort pulse).
- Synchronization and edge detection:
  - SCLK and spi_cs_n each pass through SYNC_STAGES flops plus one edge-detect flop.
  - This yields sclk_rise, sclk_fall, cs_fall and cs_rise strobes.
  - Edge latency from the pin is SYNC_STAGES+1 clk cycles.
- Handshake:
  - tx_ready = !hold_full, registered.
  - Accepting a byte sets hold_full the next cycle.
  - A load point clears hold_full.
  - If a load point and an accept fall in the same cycle with the holding register empty: IDLE_BYTE is loaded (underrun pulses) and the new byte is captured into the holding register.
- States (shared package enum): IDLE, SHIFT.
- IDLE:
  - cipo_oe=0; CIPO holds its last value.
  - On cs_fall: load point, bit_cnt=0, cipo_oe=1, CIPO=shift[MSB], go to SHIFT.
  - The MSB is therefore on CIPO before the first SCLK rise.
- SHIFT, on sclk_rise:
  - bit_cnt increments.
  - On reaching DATA_WIDTH it wraps to 0 and byte_sent pulses.
- SHIFT, on sclk_fall:
  - If bit_cnt==0 (a word just completed): load point for the next word; CIPO=new MSB.
  - Otherwise: shift left by 1; CIPO=next bit.
- SHIFT, on cs_rise:
  - cipo_oe=0, go to IDLE.
  - If bit_cnt != 0, pulse frame_abort and discard the partial word.
  - The holding register is preserved.
  - A byte loaded at the final sclk_fall of a frame that never gets clocked is lost; this is not counted as an abort.
- Load point:
  - hold_full=1: shift <= holding, hold_full <= 0.
  - hold_full=0: shift <= IDLE_BYTE, underrun pulses.
- Edge priority in one cycle: cs_rise > cs_fall > sclk edges. SCLK edges while spi_cs_n is high are ignored.
- bit_cnt width is $clog2(DATA_WIDTH)+1; the compare is against DATA_WIDTH.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_WORD_W = 8
  - SPI_IDLE_BYTE = 8'hFF
  - typedef enum logic {SPI_TX_IDLE, SPI_TX_SHIFT} spi_tx_state_t
- Sub-module spi_sync_edge:
  - Parameterized SYNC_STAGES and RESET_VAL.
  - Outputs the synchronized level plus rise and fall strobes.
  - Instantiated once for SCLK and once for spi_cs_n.
  - Reusable by spi_peripheral.

Test Plan:
- Push 8'hA5 while idle, assert CS, apply 8 SCLK pulses at clk/8 → controller samples 1,0,1,0,0,1,0,1 on rising edges; one byte_sent pulse; tx_ready=1 afterwards.
- Push 8'h3C, start the frame, push 8'hC3 during bit 3, clock 16 bits → 8'h3C then 8'hC3 received back to back; two byte_sent pulses; no underrun.
- Empty holding register, CS low, clock 8 bits → 8'hFF received; one underrun pulse at cs_fall.
- Push 8'h81, clock 4 bits, raise CS → frame_abort pulses once; cipo_oe=0; a new byte is accepted only after a new frame loads; the next frame sends IDLE_BYTE then the later-pushed byte.
- Assert rst during bit 5 of 8'h5A → all outputs return to reset values the next cycle; the next frame with an empty buffer sends 8'hFF; no frame_abort pulse.
- Toggle SCLK with CS high, holding 8'h12 → no shifting, no pulses, cipo_oe=0; the next valid frame sends 8'h12.
